ttt_move_tracker: RTL and testbench
===================================

Name: ttt_move_tracker

Overview:
- Sits directly upstream of the tic-tac-toe computer-move FSM.
- Turns the player's switch/button entry into a validated, held `h_move` for the FSM.
- Samples the FSM's `c_move` reply after a fixed latency and keeps both players' board occupancy.
- Detects win, draw and illegal computer moves, and ends the game.

Parameters:
- C_LAT, 2, cycles from an `h_move` update (or reset release) to sampling `c_move`; legal range 1..7.
- NO_MOVE, 4'hF, `h_move` value driven when no human move has been accepted.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- sw_square  in  4  square index 0..8 selected by the player
- enter  in  1  player commit button, level
- c_move  in  4  computer move from the move FSM, square 0..8
- h_move  out  4  accepted human move, held until the next accept
- h_valid  out  1  one-cycle pulse in the cycle `h_move` first shows a new value
- err  out  1  one-cycle pulse on a rejected entry
- board_h  out  9  squares owned by the human, bit i = square i
- board_c  out  9  squares owned by the computer
- game_over  out  1  high once the game has ended
- winner  out  2  00 none/draw, 01 human, 10 computer, 11 fault

Behaviour:
- Reset (rst=0 at a clock edge), taking effect even mid-game:
  - `h_move` = NO_MOVE; `h_valid`, `err`, `game_over` = 0; `board_h`, `board_c` = 0; `winner` = 00.
  - `enter_q` = 1, so a button held through reset is not counted as a press.
  - State returns to INIT.
- Edge detect: `press` = `enter` & ~`enter_q`, where `enter_q` is `enter` registered every cycle in all states.
- States:
  - INIT: count C_LAT cycles after reset release, then sample `c_move` into `board_c` (the computer's opening move) -> WAIT_H. If sampled `c_move` > 8 -> DONE with `winner` = 11.
  - WAIT_H, on `press` in cycle N:
    - Legal (`sw_square` <= 8 and bit not set in `board_h` | `board_c`): at the end of N, `h_move` <= `sw_square`, set the `board_h` bit, -> WAIT_C. `h_valid` = 1 in cycle N+1 only.
    - Illegal: `err` = 1 in cycle N+1 only; boards and `h_move` unchanged; stay in WAIT_H.
    - `h_valid` and `err` are never high together.
  - WAIT_C, entered in cycle N+1:
    - If `board_h` contains a win line -> DONE, `winner` = 01.
    - Else if all 9 squares are occupied -> DONE, `winner` = 00.
    - Otherwise count cycles N+1 .. N+C_LAT, sample `c_move` at the edge ending cycle N+C_LAT, -> CAPT.
  - CAPT, one cycle:
    - Sampled value > 8 or already occupied -> DONE, `winner` = 11.
    - Otherwise set the `board_c` bit, then:
      - `board_c` has a win line -> DONE, `winner` = 10;
      - all squares full -> DONE, `winner` = 00;
      - otherwise -> WAIT_H.
  - DONE: `game_over` = 1 from the first cycle in DONE. Everything frozen until reset; `press` ignored, no `err`.
- `press` in INIT, WAIT_C or CAPT is ignored and not queued; no `err`.
- Win lines (8 total):
  - rows {0,1,2} {3,4,5} {6,7,8}
  - columns {0,3,6} {1,4,7} {2,5,8}
  - diagonals {0,4,8} {2,4,6}
- Win and full-board tests are combinational on the registered boards. Human-win is checked before full-board.
- `h_move` is only ever NO_MOVE or a value 0..8; it is stable at all times except the single update edge.

Test Plan:
- Release reset with `c_move`=4 held -> after C_LAT=2 cycles, `board_c`=9'h010, state WAIT_H, `h_move`=4'hF, `winner`=00.
- Reset, then press 7, FSM reply 2, press 6, FSM reply 8, press 0, FSM reply 5 -> `board_h`=9'h0C1, `board_c`=9'h134 (line 2-5-8), `game_over`=1, `winner`=10; a later press produces no `h_valid`/`err`.
- Press 7 (reply 2), then press 1 (reply 6) -> `board_c` bits 2,4,6 set, `winner`=10, `h_move`=1 held.
- After reset, press with `sw_square`=4 (occupied) -> `err` pulses 1 cycle, `board_h`=0, no `h_valid`; `sw_square`=9 -> `err` pulse; `sw_square`=7 -> `h_valid` pulse, `h_move`=7.
- Hold `enter` high 5 cycles with `sw_square`=3, including across a reset pulse -> at most one `h_valid` after reset; no spurious accept from the held button.
- Force `c_move`=7 in the CAPT sample after human move 7 -> DONE, `winner`=11, `game_over`=1; apply rst=0 for 1 cycle -> all outputs back to reset values, INIT restarts.

Source files
------------

// File: rtl/ttt_move_tracker_if.sv
// Player/computer move bus between the move tracker and its surroundings.
// The slave side is the tracker; the master side drives entry and c_move.
interface ttt_move_tracker_if;
  logic [3:0] sw_square;
  logic       enter;
  logic [3:0] c_move;
  logic [3:0] h_move;
  logic       h_valid;
  logic       err;
  logic [8:0] board_h;
  logic [8:0] board_c;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output sw_square, enter, c_move,
    input  h_move, h_valid, err, board_h, board_c, game_over, winner
  );

  modport slave (
    input  sw_square, enter, c_move,
    output h_move, h_valid, err, board_h, board_c, game_over, winner
  );
endinterface

// File: rtl/ttt_move_tracker.sv
// Validates human entries, samples the computer reply C_LAT cycles after each
// h_move update, tracks both boards and ends the game on win, draw or fault.
module ttt_move_tracker #(
  parameter int unsigned C_LAT   = 2,
  parameter logic [3:0]  NO_MOVE = 4'hF
) (
  input logic               clk,
  input logic               rst,
  ttt_move_tracker_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_H,
    S_WAIT_C,
    S_CAPT,
    S_DONE
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(C_LAT - 1);
  localparam logic [8:0] FULL     = 9'h1FF;
  localparam logic [8:0] WIN_MASK [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       enter_q;
  logic [3:0] h_move_q, h_move_d;
  logic       h_valid_q, h_valid_d;
  logic       err_q, err_d;
  logic [8:0] board_h_q, board_h_d;
  logic [8:0] board_c_q, board_c_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] c_samp_q, c_samp_d;

  logic       press;
  logic [8:0] occ;
  logic [8:0] sw_bit;
  logic [8:0] cmove_bit;
  logic [8:0] samp_bit;
  logic [8:0] board_c_nx;
  logic [7:0] h_line;
  logic [7:0] c_line;
  logic       h_win;
  logic       c_win_nx;
  logic       sw_legal;
  logic       samp_bad;

  function automatic logic [8:0] sq_bit(input logic [3:0] sq);
    sq_bit = (sq <= 4'd8) ? (9'd1 << sq) : 9'd0;
  endfunction

  assign press      = bus.enter & ~enter_q;
  assign occ        = board_h_q | board_c_q;
  assign sw_bit     = sq_bit(bus.sw_square);
  assign cmove_bit  = sq_bit(bus.c_move);
  assign samp_bit   = sq_bit(c_samp_q);
  assign board_c_nx = board_c_q | samp_bit;
  assign sw_legal   = (bus.sw_square <= 4'd8) && ((occ & sw_bit) == 9'd0);
  assign samp_bad   = (c_samp_q > 4'd8) || ((occ & samp_bit) != 9'd0);

  // Computer win is judged on the board including the reply being captured,
  // so the game ends straight out of CAPT.
  for (genvar gi = 0; gi < 8; gi++) begin : g_win
    assign h_line[gi] = (board_h_q & WIN_MASK[gi]) == WIN_MASK[gi];
    assign c_line[gi] = (board_c_nx & WIN_MASK[gi]) == WIN_MASK[gi];
  end

  assign h_win    = |h_line;
  assign c_win_nx = |c_line;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_move_d  = h_move_q;
    h_valid_d = 1'b0;
    err_d     = 1'b0;
    board_h_d = board_h_q;
    board_c_d = board_c_q;
    winner_d  = winner_q;
    c_samp_d  = c_samp_q;

    unique case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 3'd0;
          if (bus.c_move > 4'd8) begin
            winner_d = 2'b11;
            state_d  = S_DONE;
          end else begin
            board_c_d = board_c_q | cmove_bit;
            state_d   = S_WAIT_H;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_WAIT_H: begin
        if (press) begin
          if (sw_legal) begin
            h_move_d  = bus.sw_square;
            board_h_d = board_h_q | sw_bit;
            h_valid_d = 1'b1;
            cnt_d     = 3'd0;
            state_d   = S_WAIT_C;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_WAIT_C: begin
        if (h_win) begin
          winner_d = 2'b01;
          state_d  = S_DONE;
        end else if (occ == FULL) begin
          winner_d = 2'b00;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          c_samp_d = bus.c_move;
          cnt_d    = 3'd0;
          state_d  = S_CAPT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_CAPT: begin
        if (samp_bad) begin
          winner_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          board_c_d = board_c_nx;
          if (c_win_nx) begin
            winner_d = 2'b10;
            state_d  = S_DONE;
          end else if ((board_h_q | board_c_nx) == FULL) begin
            winner_d = 2'b00;
            state_d  = S_DONE;
          end else begin
            state_d = S_WAIT_H;
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // enter_q comes out of reset high so a button held through reset is no press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_INIT;
      cnt_q     <= 3'd0;
      enter_q   <= 1'b1;
      h_move_q  <= NO_MOVE;
      h_valid_q <= 1'b0;
      err_q     <= 1'b0;
      board_h_q <= 9'd0;
      board_c_q <= 9'd0;
      winner_q  <= 2'b00;
      c_samp_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      enter_q   <= bus.enter;
      h_move_q  <= h_move_d;
      h_valid_q <= h_valid_d;
      err_q     <= err_d;
      board_h_q <= board_h_d;
      board_c_q <= board_c_d;
      winner_q  <= winner_d;
      c_samp_q  <= c_samp_d;
    end
  end

  assign bus.h_move    = h_move_q;
  assign bus.h_valid   = h_valid_q;
  assign bus.err       = err_q;
  assign bus.board_h   = board_h_q;
  assign bus.board_c   = board_c_q;
  assign bus.game_over = (state_q == S_DONE);
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_ttt_move_tracker.sv
// Scoreboard bench: a game-level model predicts h_valid/err/game-end events,
// a monitor pops and compares them as the tracker presents them.
module tb_ttt_move_tracker;
  localparam int C_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ttt_move_tracker_if bus();

  ttt_move_tracker #(.C_LAT(C_LAT), .NO_MOVE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         kind;   // 0 h_valid, 1 err, 2 game end
    int         hm;
    logic [8:0] bh;
    logic [8:0] bc;
    int         win;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // game-level reference model
  bit hb[9];
  bit cb[9];
  bit over;
  int last_h;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit won(input bit b[9]);
    for (int l = 0; l < 8; l++)
      if (b[lines[l][0]] && b[lines[l][1]] && b[lines[l][2]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit full();
    for (int i = 0; i < 9; i++)
      if (!(hb[i] || cb[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [8:0] pack(input bit b[9]);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = b[i];
    return r;
  endfunction

  function automatic int free_sq();
    int fq[$];
    for (int i = 0; i < 9; i++)
      if (!(hb[i] || cb[i])) fq.push_back(i);
    if (fq.size() == 0) return 0;
    return fq[$urandom_range(0, fq.size() - 1)];
  endfunction

  task automatic push(input int kind, input int win);
    ev_t e;
    e.kind = kind;
    e.hm   = last_h;
    e.bh   = pack(hb);
    e.bc   = pack(cb);
    e.win  = win;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int opening);
    for (int i = 0; i < 9; i++) begin
      hb[i] = 1'b0;
      cb[i] = 1'b0;
    end
    over   = 1'b0;
    last_h = 15;
    if (opening > 8) begin
      over = 1'b1;
      push(2, 3);
    end else begin
      cb[opening] = 1'b1;
    end
  endtask

  task automatic do_reset(input int opening);
    @(negedge clk);
    rst        = 1'b0;
    bus.c_move = 4'(opening);
    @(negedge clk);
    chk("rst_h_move",    16'(bus.h_move),    16'hF);
    chk("rst_h_valid",   16'(bus.h_valid),   16'h0);
    chk("rst_err",       16'(bus.err),       16'h0);
    chk("rst_game_over", 16'(bus.game_over), 16'h0);
    chk("rst_board_h",   16'(bus.board_h),   16'h0);
    chk("rst_board_c",   16'(bus.board_c),   16'h0);
    chk("rst_winner",    16'(bus.winner),    16'h0);
    rst = 1'b1;
    model_reset(opening);
    repeat (C_LAT + 2) @(negedge clk);
    chk("open_board_c", 16'(bus.board_c), 16'(pack(cb)));
    $display("[TB] reset opening=%0d board_c=%03h game_over=%0d", opening, bus.board_c, bus.game_over);
  endtask

  // reply < 0 picks a free square after the human move
  task automatic press(input int sq, input int reply);
    int r;
    @(negedge clk);
    bus.sw_square = 4'(sq);
    bus.enter     = 1'b1;
    r = reply;
    if (!over) begin
      if (sq > 8 || hb[sq] || cb[sq]) begin
        push(1, 0);
      end else begin
        hb[sq] = 1'b1;
        last_h = sq;
        if (r < 0) r = free_sq();
        bus.c_move = 4'(r);
        push(0, 0);
        if (won(hb)) begin
          over = 1'b1;
          push(2, 1);
        end else if (full()) begin
          over = 1'b1;
          push(2, 0);
        end else if (r > 8 || hb[r] || cb[r]) begin
          over = 1'b1;
          push(2, 3);
        end else begin
          cb[r] = 1'b1;
          if (won(cb)) begin
            over = 1'b1;
            push(2, 2);
          end else if (full()) begin
            over = 1'b1;
            push(2, 0);
          end
        end
      end
    end
    @(negedge clk);
    bus.enter = 1'b0;
    repeat (C_LAT + 5) @(negedge clk);
    $display("[TB] press sq=%0d reply=%0d h_move=%0d board_h=%03h board_c=%03h over=%0d winner=%0d",
             sq, r, bus.h_move, bus.board_h, bus.board_c, bus.game_over, bus.winner);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d h_move=%0d, expected no event", kind, bus.h_move);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.hm != int'(bus.h_move) || e.bh !== bus.board_h ||
          e.bc !== bus.board_c || e.win != int'(bus.winner)) begin
        fails++;
        $display("FAIL event: got kind=%0d hm=%0d bh=%03h bc=%03h win=%0d, expected kind=%0d hm=%0d bh=%03h bc=%03h win=%0d",
                 kind, bus.h_move, bus.board_h, bus.board_c, bus.winner,
                 e.kind, e.hm, e.bh, e.bc, e.win);
      end
    end
  endtask

  // monitor
  initial begin
    bit go_prev;
    go_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        go_prev = 1'b0;
        continue;
      end
      if (bus.h_valid && bus.err) begin
        tests++;
        fails++;
        $display("FAIL hv_err_overlap: got h_valid=1 err=1, expected not both");
      end
      if (bus.h_valid) check_ev(0);
      if (bus.err) check_ev(1);
      if (bus.game_over && !go_prev) check_ev(2);
      go_prev = bus.game_over;
    end
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sw_square = 4'd0;
    bus.enter     = 1'b0;
    bus.c_move    = 4'd4;

    // opening move and a computer win on 2-5-8
    do_reset(4);
    chk("init_h_move", 16'(bus.h_move), 16'hF);
    press(7, 2);
    press(6, 8);
    press(0, 5);
    chk("g1_board_h",   16'(bus.board_h),   16'h0C1);
    chk("g1_board_c",   16'(bus.board_c),   16'h134);
    chk("g1_game_over", 16'(bus.game_over), 16'h1);
    chk("g1_winner",    16'(bus.winner),    16'h2);
    press(3, 1);

    // diagonal computer win, last human move held
    do_reset(4);
    press(7, 2);
    press(1, 6);
    chk("g2_winner", 16'(bus.winner), 16'h2);
    chk("g2_h_move", 16'(bus.h_move), 16'h1);

    // rejected entries then an accepted one
    do_reset(4);
    press(4, 0);
    chk("g3_board_h", 16'(bus.board_h), 16'h0);
    press(9, 0);
    press(7, 3);
    chk("g3_h_move", 16'(bus.h_move), 16'h7);

    // enter held across a reset pulse
    @(negedge clk);
    bus.sw_square = 4'd3;
    bus.enter     = 1'b1;
    bus.c_move    = 4'd4;
    rst           = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset(4);
    repeat (4) @(negedge clk);
    bus.enter = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_board_h", 16'(bus.board_h), 16'h0);
    chk("hold_h_move",  16'(bus.h_move),  16'hF);
    press(3, 0);

    // computer replies on the human's square
    do_reset(4);
    press(7, 7);
    chk("fault_winner",    16'(bus.winner),    16'h3);
    chk("fault_game_over", 16'(bus.game_over), 16'h1);
    do_reset(4);

    // randomized games
    for (int g = 0; g < 30; g++) begin
      int opening;
      opening = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      do_reset(opening);
      for (int m = 0; m < 12; m++) begin
        int sq;
        int rep;
        bit was_over;
        was_over = over;
        sq  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : free_sq();
        rep = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : -1;
        press(sq, rep);
        if (was_over) break;
      end
    end

    repeat (10) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
